// File: rtl/mips_trace_buffer_if.sv
// rtl/mips_trace_buffer_if.sv - CPU observation bus and trace readout stream
interface mips_trace_buffer_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] inst;
    logic [DATA_W-1:0] alu_out;
    logic              reg_write;
    logic              mem_write;
    logic              pcsrc;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_pc;
    logic [DATA_W-1:0] rd_inst;
    logic [DATA_W-1:0] rd_alu;

    modport master (
        output pc, inst, alu_out, reg_write, mem_write, pcsrc, rd_ready,
        input  rd_valid, rd_pc, rd_inst, rd_alu
    );

    modport slave (
        input  pc, inst, alu_out, reg_write, mem_write, pcsrc, rd_ready,
        output rd_valid, rd_pc, rd_inst, rd_alu
    );
endinterface

// File: rtl/mips_trace_buffer.sv
// rtl/mips_trace_buffer.sv - triggered one-shot CPU trace capture buffer with drain-to-idle readout
module mips_trace_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   arm,
    input  logic                   mode,
    input  logic [DATA_W-1:0]      trig_pc,
    output logic [1:0]             state,
    output logic [$clog2(DEPTH):0] count,
    mips_trace_buffer_if.slave     bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        CAPTURE = 2'b10,
        DONE    = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic              mode_q;
    logic [DATA_W-1:0] trig_q;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count_q;

    logic [DATA_W-1:0] mem_pc   [DEPTH];
    logic [DATA_W-1:0] mem_inst [DEPTH];
    logic [DATA_W-1:0] mem_alu  [DEPTH];

    logic trig_hit, qualified, do_write, do_pop, arm_take;

    assign arm_take  = (state_q == IDLE) && arm;
    assign trig_hit  = (state_q == ARMED) && (bus.pc == trig_q);
    assign qualified = !mode_q || bus.reg_write || bus.mem_write || bus.pcsrc;
    // The trigger cycle itself is the first capture-eligible cycle.
    assign do_write  = (trig_hit || (state_q == CAPTURE)) && qualified;
    assign do_pop    = bus.rd_valid && bus.rd_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arm) state_d = ARMED;
            ARMED:   if (trig_hit) state_d = CAPTURE;
            CAPTURE: if (do_write && (count_q == CW'(DEPTH - 1))) state_d = DONE;
            DONE:    if (do_pop && (count_q == CW'(1))) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_q  <= 1'b0;
            trig_q  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (arm_take) begin
                mode_q <= mode;
                trig_q <= trig_pc;
            end
            if (do_write) begin
                wr_ptr  <= wr_ptr + AW'(1);
                count_q <= count_q + CW'(1);
            end else if (do_pop) begin
                count_q <= count_q - CW'(1);
                // Draining the last record returns both pointers to the origin.
                if (count_q == CW'(1)) begin
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                end else begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_write) begin
            mem_pc[wr_ptr]   <= bus.pc;
            mem_inst[wr_ptr] <= bus.inst;
            mem_alu[wr_ptr]  <= bus.alu_out;
        end
    end

    assign bus.rd_valid = (state_q == DONE) && (count_q != '0);
    assign bus.rd_pc    = mem_pc[rd_ptr];
    assign bus.rd_inst  = mem_inst[rd_ptr];
    assign bus.rd_alu   = mem_alu[rd_ptr];
    assign state        = state_q;
    assign count        = count_q;
endmodule

// File: tb/tb_mips_trace_buffer.sv
// tb/tb_mips_trace_buffer.sv - directed self-checking bench for mips_trace_buffer
module tb_mips_trace_buffer;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clock;
    logic              reset;
    logic              arm;
    logic              mode;
    logic [DATA_W-1:0] trig_pc;
    logic [1:0]        state;
    logic [2:0]        count;

    int n_cmp;
    int n_err;

    mips_trace_buffer_if #(.DATA_W(DATA_W)) bus ();

    mips_trace_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset   (reset),
        .arm     (arm),
        .mode    (mode),
        .trig_pc (trig_pc),
        .state   (state),
        .count   (count),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one CPU cycle (inst/alu derived from pc) and advance past the edge.
    task automatic cyc(input logic [31:0] p, input logic rw, input logic mw, input logic ps);
        bus.pc        = p;
        bus.inst      = p + 32'h100;
        bus.alu_out   = p + 32'h200;
        bus.reg_write = rw;
        bus.mem_write = mw;
        bus.pcsrc     = ps;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [31:0] exp_pc [4];
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        arm = 1'b0;
        mode = 1'b0;
        trig_pc = '0;
        bus.pc = '0; bus.inst = '0; bus.alu_out = '0;
        bus.reg_write = 1'b0; bus.mem_write = 1'b0; bus.pcsrc = 1'b0;
        bus.rd_ready = 1'b0;
        #12;
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_rd_valid", 64'(bus.rd_valid), 64'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        // Continuous capture, trigger at 0x08
        mode = 1'b0; trig_pc = 32'h08; arm = 1'b1;
        cyc(32'h00, 0, 0, 0);
        arm = 1'b0;
        chk("t1_armed", 64'(state), 64'd1);
        cyc(32'h04, 0, 0, 0);
        chk("t1_still_armed", 64'(state), 64'd1);
        cyc(32'h08, 0, 0, 0);
        chk("t1_capture", 64'(state), 64'd2);
        chk("t1_count1", 64'(count), 64'd1);
        cyc(32'h0C, 0, 0, 0);
        cyc(32'h10, 0, 0, 0);
        chk("t1_count3", 64'(count), 64'd3);
        chk("t1_no_valid_cap", 64'(bus.rd_valid), 64'd0);
        cyc(32'h14, 0, 0, 0);
        chk("t1_done", 64'(state), 64'd3);
        chk("t1_count4", 64'(count), 64'd4);
        chk("t1_valid", 64'(bus.rd_valid), 64'd1);
        cyc(32'h18, 0, 0, 0);
        chk("t1_no_overwrite", 64'(count), 64'd4);
        exp_pc[0] = 32'h08; exp_pc[1] = 32'h0C; exp_pc[2] = 32'h10; exp_pc[3] = 32'h14;
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_rd_pc%0d", i), 64'(bus.rd_pc), 64'(exp_pc[i]));
            chk($sformatf("t1_rd_inst%0d", i), 64'(bus.rd_inst), 64'(exp_pc[i] + 32'h100));
            chk($sformatf("t1_rd_alu%0d", i), 64'(bus.rd_alu), 64'(exp_pc[i] + 32'h200));
            cyc(32'h20, 0, 0, 0);
        end
        chk("t1_idle", 64'(state), 64'd0);
        chk("t1_count0", 64'(count), 64'd0);
        chk("t1_valid0", 64'(bus.rd_valid), 64'd0);
        cyc(32'h24, 0, 0, 0);
        chk("t1_ready_no_effect", 64'(count), 64'd0);
        bus.rd_ready = 1'b0;

        // Qualified capture, trigger at 0x00
        mode = 1'b1; trig_pc = 32'h00; arm = 1'b1;
        cyc(32'hFC, 0, 0, 0);
        arm = 1'b0; mode = 1'b0;
        cyc(32'h00, 0, 0, 0);
        chk("t2_capture", 64'(state), 64'd2);
        chk("t2_trig_unqual", 64'(count), 64'd0);
        cyc(32'h04, 1, 0, 0);
        cyc(32'h08, 0, 0, 0);
        cyc(32'h0C, 0, 0, 0);
        chk("t2_count1", 64'(count), 64'd1);
        cyc(32'h10, 1, 0, 0);
        cyc(32'h14, 0, 0, 0);
        cyc(32'h18, 0, 1, 0);
        chk("t2_count3", 64'(count), 64'd3);
        chk("t2_still_capture", 64'(state), 64'd2);
        cyc(32'h1C, 0, 0, 1);
        chk("t2_done", 64'(state), 64'd3);
        chk("t2_count4", 64'(count), 64'd4);

        // Readout with rd_ready toggling 1,0,1,0
        chk("t3_head", 64'(bus.rd_pc), 64'h04);
        bus.rd_ready = 1'b1; cyc(32'h0, 0, 0, 0);
        chk("t3_c3a", 64'(count), 64'd3);
        bus.rd_ready = 1'b0; cyc(32'h0, 0, 0, 0);
        chk("t3_c3b", 64'(count), 64'd3);
        chk("t3_valid_hold", 64'(bus.rd_valid), 64'd1);
        chk("t3_pc_hold", 64'(bus.rd_pc), 64'h10);
        bus.rd_ready = 1'b1; cyc(32'h0, 0, 0, 0);
        chk("t3_c2a", 64'(count), 64'd2);
        bus.rd_ready = 1'b0; cyc(32'h0, 0, 0, 0);
        chk("t3_c2b", 64'(count), 64'd2);
        chk("t3_valid2", 64'(bus.rd_valid), 64'd1);
        chk("t3_pc3", 64'(bus.rd_pc), 64'h18);
        bus.rd_ready = 1'b1; cyc(32'h0, 0, 0, 0);
        chk("t3_pc4", 64'(bus.rd_pc), 64'h1C);
        cyc(32'h0, 0, 0, 0);
        bus.rd_ready = 1'b0;
        chk("t3_idle", 64'(state), 64'd0);

        // Arm ignored during CAPTURE and DONE
        mode = 1'b0; trig_pc = 32'h40; arm = 1'b1;
        cyc(32'h3C, 0, 0, 0);
        arm = 1'b0;
        cyc(32'h40, 0, 0, 0);
        arm = 1'b1; trig_pc = 32'h44;
        cyc(32'h44, 0, 0, 0);
        arm = 1'b0; mode = 1'b1;
        chk("t4_capture", 64'(state), 64'd2);
        chk("t4_count2", 64'(count), 64'd2);
        cyc(32'h48, 0, 0, 0);
        chk("t4_mode_latched", 64'(count), 64'd3);
        cyc(32'h4C, 0, 0, 0);
        chk("t4_done", 64'(state), 64'd3);
        arm = 1'b1;
        cyc(32'h50, 0, 0, 0);
        arm = 1'b0;
        chk("t4_done_arm_ignored", 64'(state), 64'd3);
        chk("t4_head", 64'(bus.rd_pc), 64'h40);
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc(32'h0, 0, 0, 0);
        bus.rd_ready = 1'b0;
        chk("t4_idle", 64'(state), 64'd0);

        // Asynchronous reset mid-capture
        mode = 1'b0; trig_pc = 32'h80; arm = 1'b1;
        cyc(32'h7C, 0, 0, 0);
        arm = 1'b0;
        cyc(32'h80, 0, 0, 0);
        cyc(32'h84, 0, 0, 0);
        chk("t5_count2", 64'(count), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_rst_state", 64'(state), 64'd0);
        chk("t5_rst_count", 64'(count), 64'd0);
        chk("t5_rst_valid", 64'(bus.rd_valid), 64'd0);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) cyc(32'h80 + 32'(4 * i), 0, 0, 0);
        chk("t5_wait_idle", 64'(state), 64'd0);
        chk("t5_no_valid", 64'(bus.rd_valid), 64'd0);

        // Trigger never matched
        trig_pc = 32'hDEAD_0000; arm = 1'b1;
        cyc(32'h0, 0, 0, 0);
        arm = 1'b0;
        for (int i = 0; i < 100; i++) cyc(32'(4 * i), 1, 0, 0);
        chk("t6_armed", 64'(state), 64'd1);
        chk("t6_count0", 64'(count), 64'd0);
        chk("t6_valid0", 64'(bus.rd_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
